// File: rtl/spi_flash_reader.sv
// SPI-master read engine for M25P16-style flash: sends READ (0x03) plus a
// 24-bit address, streams len bytes from SPIMISO into a small FIFO, and
// drains the FIFO through a valid/ready port. SPICLK is stalled at byte
// boundaries while the FIFO is full, keeping chip_select asserted.
module spi_flash_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             SPICLK,
    output logic             SPIMOSI,
    input  logic             SPIMISO,
    output logic             chip_select
);

    localparam int           AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0]   READ_CMD = 8'h03;
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, CMD, ADDR, DATA, PAUSE, CS_HOLD, DONE
    } state_t;

    state_t           state_q, state_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;

    // Header bits still to send after the one on SPIMOSI, and received bits 7..1.
    logic [30:0]      hdr_q;
    logic [6:0]       rx_q;
    logic             hdr_ld, hdr_shift, rx_shift, push;
    logic [7:0]       push_data;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop, fifo_full;

    assign pop       = rd_valid & rd_ready;
    assign fifo_full = (count_q == FULL_CNT);
    assign push_data = {rx_q, SPIMISO};

    assign rd_valid    = (count_q != '0);
    assign rd_data     = mem[rd_ptr_q];
    assign SPICLK      = sck_q;
    assign SPIMOSI     = mosi_q;
    assign chip_select = cs_n_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);

    // Control state register; SPI pins are registered so they never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Next-state and next-pin logic; every bit is a low phase then a high phase.
    always_comb begin
        state_d    = state_q;
        sck_d      = 1'b0;
        mosi_d     = 1'b0;
        cs_n_d     = 1'b1;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        hdr_ld     = 1'b0;
        hdr_shift  = 1'b0;
        rx_shift   = 1'b0;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d    = CS_SETUP;
                        cs_n_d     = 1'b0;
                        mosi_d     = READ_CMD[7];
                        hdr_ld     = 1'b1;
                        byte_cnt_d = len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            // CS_SETUP doubles as the low phase of command bit 7.
            CS_SETUP: begin
                state_d   = CMD;
                cs_n_d    = 1'b0;
                sck_d     = 1'b1;
                mosi_d    = mosi_q;
                bit_cnt_d = 5'd7;
            end
            CMD, ADDR: begin
                cs_n_d = 1'b0;
                if (!sck_q) begin
                    sck_d  = 1'b1;
                    mosi_d = mosi_q;
                end else begin
                    hdr_shift = 1'b1;
                    mosi_d    = hdr_q[30];
                    if (bit_cnt_q == 5'd0) begin
                        if (state_q == CMD) begin
                            state_d   = ADDR;
                            bit_cnt_d = 5'd23;
                        end else begin
                            state_d   = DATA;
                            bit_cnt_d = 5'd7;
                            mosi_d    = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            DATA: begin
                cs_n_d = 1'b0;
                if (!sck_q) begin
                    // Reserve a FIFO slot before committing to a new byte.
                    if (bit_cnt_q == 5'd7 && fifo_full)
                        state_d = PAUSE;
                    else
                        sck_d = 1'b1;
                end else begin
                    rx_shift = 1'b1;
                    if (bit_cnt_q == 5'd0) begin
                        push       = 1'b1;
                        bit_cnt_d  = 5'd7;
                        byte_cnt_d = byte_cnt_q - LEN_W'(1);
                        if (byte_cnt_q == LEN_W'(1))
                            state_d = CS_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            PAUSE: begin
                cs_n_d = 1'b0;
                if (!fifo_full) begin
                    state_d = DATA;
                    sck_d   = 1'b1;
                end
            end
            CS_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift registers and FIFO storage carry data only, so they have no reset.
    always_ff @(posedge clk) begin
        if (hdr_ld)
            hdr_q <= {READ_CMD[6:0], addr};
        else if (hdr_shift)
            hdr_q <= {hdr_q[29:0], 1'b0};
        if (rx_shift)
            rx_q <= {rx_q[5:0], SPIMISO};
        if (push)
            mem[wr_ptr_q] <= push_data;
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Testbench for spi_flash_reader: M25P16 read model on the SPI pins, a
// queue-based scoreboard for the consumer port, and directed scenarios.
module tb_spi_flash_reader;

    localparam int LEN_W      = 16;
    localparam int FIFO_DEPTH = 4;

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic             start    = 1'b0;
    logic [23:0]      addr     = '0;
    logic [LEN_W-1:0] len      = '0;
    logic             rd_ready = 1'b0;
    logic             SPIMISO  = 1'b0;
    logic             busy, done, rd_valid, SPICLK, SPIMOSI, chip_select;
    logic [7:0]       rd_data;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_q [$];

    int          edge_cnt = 0, done_cnt = 0, cs_fall_cnt = 0, mosi_bad = 0;
    int          edge_base = 0, done_base = 0, cs_base = 0, bad_base = 0;
    int          fl_bits = 0;
    logic [31:0] fl_hdr = '0;

    spi_flash_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI),
        .SPIMISO(SPIMISO), .chip_select(chip_select)
    );

    always #5 clk = ~clk;

    // Flash array contents: three preloaded bytes, a simple pattern elsewhere.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'hA5;
            24'h000101: return 8'h5A;
            24'h000102: return 8'h3C;
            default:    return a[7:0] ^ 8'h96;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Flash model: latches command/address on SPICLK rises while selected.
    always @(posedge SPICLK or posedge chip_select) begin
        if (chip_select) begin
            fl_bits = 0;
        end else begin
            if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], SPIMOSI};
            else if (SPIMOSI) mosi_bad++;
            fl_bits++;
        end
    end

    // Flash model: presents the next data bit after each SPICLK fall.
    always @(negedge SPICLK) begin : flash_tx
        int k;
        logic [7:0] b;
        if (!chip_select && fl_bits >= 32) begin
            k = fl_bits - 32;
            b = flash_byte(fl_hdr[23:0] + 24'(k / 8));
            SPIMISO = b[7 - (k % 8)];
        end
    end

    always @(posedge SPICLK) edge_cnt++;
    always @(negedge chip_select) cs_fall_cnt++;
    always @(negedge clk) if (done) done_cnt++;

    // Scoreboard monitor: every accepted byte is compared with the queue head.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL rd_data_unexpected: actual %0h required none", rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e);
            end
        end
    end

    task automatic issue(input logic [23:0] a, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        start     = 1'b1;
        addr      = a;
        len       = l;
        edge_base = edge_cnt;
        done_base = done_cnt;
        cs_base   = cs_fall_cnt;
        bad_base  = mosi_bad;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic p1_sck, p1_cs, p2_sck;
        int n;
        n = 0; p1_sck = 1'b0; p1_cs = 1'b1; p2_sck = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            if (done) break;
            p2_sck = p1_sck;
            p1_sck = SPICLK;
            p1_cs  = chip_select;
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_done_cs"}, chip_select, 1'b1);
        check({tag, "_done_busy"}, busy, 1'b0);
        check({tag, "_hold_sck"}, p1_sck, 1'b0);
        check({tag, "_hold_cs"}, p1_cs, 1'b0);
        check({tag, "_last_high"}, p2_sck, 1'b1);
    endtask

    task automatic finish_txn(input int edges, input logic [31:0] hdr, input string tag);
        @(negedge clk);
        check({tag, "_done_single"}, done, 1'b0);
        check({tag, "_cs_idle"}, chip_select, 1'b1);
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_cs_falls"}, cs_fall_cnt - cs_base, 1);
        check({tag, "_edges"}, edge_cnt - edge_base, edges);
        check({tag, "_header"}, fl_hdr, hdr);
        check({tag, "_data_mosi"}, mosi_bad - bad_base, 0);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_valid_left"}, rd_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", chip_select, 1'b1);
        check("rst_sck", SPICLK, 1'b0);
        check("rst_mosi", SPIMOSI, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", rd_valid, 1'b0);
        @(posedge clk); #1;
        reset    = 1'b1;
        rd_ready = 1'b1;

        // Basic read with cycle-level timing of the opening bits.
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h3C);
        issue(24'h000100, 3);
        @(negedge clk);
        check("t1_cs", chip_select, 1'b0);
        check("t1_sck", SPICLK, 1'b0);
        check("t1_mosi", SPIMOSI, 1'b0);
        check("t1_busy", busy, 1'b1);
        @(negedge clk);
        check("t2_sck", SPICLK, 1'b1);
        check("t2_cs", chip_select, 1'b0);
        @(negedge clk);
        check("t3_sck", SPICLK, 1'b0);
        @(negedge clk);
        check("t4_sck", SPICLK, 1'b1);
        wait_done(400, "s1");
        finish_txn(56, 32'h03000100, "s1");
        wait_drain(50, "s1");

        // Backpressure: consumer stalled, engine must park after four bytes.
        @(posedge clk); #1;
        rd_ready = 1'b0;
        exp_q.push_back(8'h96); exp_q.push_back(8'h97); exp_q.push_back(8'h94); exp_q.push_back(8'h95);
        exp_q.push_back(8'h92); exp_q.push_back(8'h93); exp_q.push_back(8'h90); exp_q.push_back(8'h91);
        issue(24'h000200, 8);
        repeat (200) @(negedge clk);
        check("bp_edges", edge_cnt - edge_base, 64);
        check("bp_sck", SPICLK, 1'b0);
        check("bp_cs", chip_select, 1'b0);
        check("bp_busy", busy, 1'b1);
        check("bp_valid", rd_valid, 1'b1);
        repeat (20) @(negedge clk);
        check("bp_edges_hold", edge_cnt - edge_base, 64);
        check("bp_sck_hold", SPICLK, 1'b0);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_done(400, "bp");
        finish_txn(96, 32'h03000200, "bp");
        wait_drain(50, "bp");

        // Zero-length request completes without touching the bus.
        issue(24'h000400, 0);
        @(negedge clk);
        check("z_done", done, 1'b1);
        check("z_cs", chip_select, 1'b1);
        check("z_busy", busy, 1'b0);
        @(negedge clk);
        check("z_done_single", done, 1'b0);
        check("z_edges", edge_cnt - edge_base, 0);
        check("z_cs_falls", cs_fall_cnt - cs_base, 0);
        check("z_done_pulses", done_cnt - done_base, 1);

        // A start pulse during a transfer must be ignored.
        exp_q.push_back(8'h96); exp_q.push_back(8'h97);
        issue(24'h000300, 2);
        repeat (6) @(posedge clk); #1;
        start = 1'b1;
        addr  = 24'h000777;
        len   = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(400, "ign");
        finish_txn(48, 32'h03000300, "ign");
        repeat (40) @(negedge clk);
        check("ign_edges_after", edge_cnt - edge_base, 48);
        check("ign_busy_after", busy, 1'b0);
        check("ign_cs_after", cs_fall_cnt - cs_base, 1);
        wait_drain(50, "ign");

        // Asynchronous reset in the middle of the address phase.
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h3C);
        issue(24'h000100, 3);
        repeat (24) @(posedge clk); #2;
        check("mid_cs_active", chip_select, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_cs", chip_select, 1'b1);
        check("mid_rst_sck", SPICLK, 1'b0);
        check("mid_rst_mosi", SPIMOSI, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", rd_valid, 1'b0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;

        // Fresh transaction after reset must behave like the first one.
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h3C);
        issue(24'h000100, 3);
        wait_done(400, "rr");
        finish_txn(56, 32'h03000100, "rr");
        wait_drain(50, "rr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
